seg7_digit_ctrl: RTL and testbench

//  Wishbone-controlled single seven-segment digit engine inside user_proj_example.

---
 rtl/seg7_digit_ctrl_pkg.sv | 45 ++++
 rtl/seg7_digit_ctrl_if.sv | 24 ++
 rtl/seg7_digit_ctrl_decode.sv | 14 +
 rtl/seg7_digit_ctrl.sv | 164 ++++++++++++++++
 tb/tb_seg7_digit_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_digit_ctrl_pkg.sv
// Shared constants, register map and segment table for the seven-segment digit engine.
package seg7_digit_ctrl_pkg;

   localparam int unsigned PAD_W  = 7;
   localparam int unsigned DIG_W  = 4;
   localparam int unsigned WB_W   = 32;
   localparam int unsigned SEL_W  = 4;
   localparam int unsigned CTRL_W = 6;

   localparam logic [7:0] OFF_CTRL  = 8'h00;
   localparam logic [7:0] OFF_PRE   = 8'h04;
   localparam logic [7:0] OFF_COUNT = 8'h08;
   localparam logic [7:0] OFF_STAT  = 8'h0C;

   localparam int unsigned CTRL_EN     = 0;
   localparam int unsigned CTRL_HEX    = 1;
   localparam int unsigned CTRL_DOWN   = 2;
   localparam int unsigned CTRL_BLANK  = 3;
   localparam int unsigned CTRL_OE     = 4;
   localparam int unsigned CTRL_IRQ_EN = 5;

   // Active-high segments {g,f,e,d,c,b,a} for digits 0..F
   localparam logic [PAD_W-1:0] SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef enum logic {
      BUS_IDLE = 1'b0,
      BUS_ACK  = 1'b1
   } bus_state_t;

   // Byte-lane merge of write data into an existing register value
   function automatic logic [WB_W-1:0] wb_merge(input logic [WB_W-1:0]  old_val,
                                                input logic [WB_W-1:0]  wr_val,
                                                input logic [SEL_W-1:0] sel);
      logic [WB_W-1:0] res;
      res = old_val;
      for (int i = 0; i < int'(SEL_W); i++) begin
         if (sel[i]) res[i*8 +: 8] = wr_val[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/seg7_digit_ctrl_if.sv
// Wishbone slave bus bundle for the digit engine.
interface seg7_digit_ctrl_if;
   import seg7_digit_ctrl_pkg::*;

   logic             wbs_cyc_i;
   logic             wbs_stb_i;
   logic             wbs_we_i;
   logic [SEL_W-1:0] wbs_sel_i;
   logic [WB_W-1:0]  wbs_adr_i;
   logic [WB_W-1:0]  wbs_dat_i;
   logic             wbs_ack_o;
   logic [WB_W-1:0]  wbs_dat_o;

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );

endinterface

// File: rtl/seg7_digit_ctrl_decode.sv
// Hex digit to active-high seven-segment pattern lookup.
module seg7_digit_ctrl_decode
   import seg7_digit_ctrl_pkg::*;
(
   input  logic [DIG_W-1:0] digit,
   output logic [PAD_W-1:0] seg_c
);

   // Table lookup
   always_comb begin
      seg_c = SEG_TABLE[digit];
   end

endmodule

// File: rtl/seg7_digit_ctrl.sv
// Wishbone-controlled single seven-segment digit: prescaled up/down counter,
// segment decode, pad polarity and sticky wrap interrupt.
module seg7_digit_ctrl
   import seg7_digit_ctrl_pkg::*;
#(
   parameter logic [WB_W-1:0] BASE_ADDR = 32'h3000_0000,
   parameter int unsigned     PRE_W     = 24
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_n,
   seg7_digit_ctrl_if.slave wbs,
   input  logic             digit_pol_in,
   output logic [PAD_W-1:0] digit0_out,
   output logic [PAD_W-1:0] digit0_oeb,
   output logic             irq_o
);

   bus_state_t        state_q, state_d;
   logic              hit_c, req_c, wr_en_c, rd_en_c;
   logic              wr_ctrl_c, wr_pre_c, wr_count_c, wr_stat_c;
   logic [WB_W-1:0]   rdata_c, dat_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [PRE_W-1:0]  pre_q, pre_cnt_q;
   logic [DIG_W-1:0]  count_q, count_nx_c, limit_c;
   logic              wrap_q, wrap_hit_c, tick_c, clr_c;
   logic [1:0]        pol_q;
   logic [PAD_W-1:0]  seg_c;

   assign hit_c = wbs.wbs_adr_i[WB_W-1:8] == BASE_ADDR[WB_W-1:8];
   assign req_c = wbs.wbs_cyc_i && wbs.wbs_stb_i && hit_c;

   assign wr_ctrl_c  = wr_en_c && (wbs.wbs_adr_i[7:0] == OFF_CTRL);
   assign wr_pre_c   = wr_en_c && (wbs.wbs_adr_i[7:0] == OFF_PRE);
   assign wr_count_c = wr_en_c && (wbs.wbs_adr_i[7:0] == OFF_COUNT);
   assign wr_stat_c  = wr_en_c && (wbs.wbs_adr_i[7:0] == OFF_STAT);

   // A COUNT write overrides a coincident tick
   assign tick_c = ctrl_q[CTRL_EN] && (pre_cnt_q == '0) && !wr_count_c;
   assign clr_c  = wr_stat_c && wbs.wbs_sel_i[0] && wbs.wbs_dat_i[0];

   assign wbs.wbs_ack_o = (state_q == BUS_ACK);
   assign wbs.wbs_dat_o = dat_q;

   // Bus FSM state register
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) state_q <= BUS_IDLE;
      else           state_q <= state_d;
   end

   // Bus FSM next state; the request edge is also the register access edge
   always_comb begin
      state_d = state_q;
      wr_en_c = 1'b0;
      rd_en_c = 1'b0;
      case (state_q)
         BUS_IDLE: begin
            if (req_c) begin
               state_d = BUS_ACK;
               wr_en_c = wbs.wbs_we_i;
               rd_en_c = !wbs.wbs_we_i;
            end
         end
         BUS_ACK:  state_d = BUS_IDLE;
         default:  state_d = BUS_IDLE;
      endcase
   end

   // Read mux; unmapped in-window offsets read zero
   always_comb begin
      rdata_c = '0;
      case (wbs.wbs_adr_i[7:0])
         OFF_CTRL:  rdata_c = WB_W'(ctrl_q);
         OFF_PRE:   rdata_c = WB_W'(pre_q);
         OFF_COUNT: rdata_c = WB_W'(count_q);
         OFF_STAT:  rdata_c = WB_W'(wrap_q);
         default:   rdata_c = '0;
      endcase
   end

   // Read data presented only alongside ack
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) dat_q <= '0;
      else           dat_q <= rd_en_c ? rdata_c : '0;
   end

   // Control and prescaler reload registers
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         ctrl_q <= '0;
         pre_q  <= '0;
      end else begin
         if (wr_ctrl_c) ctrl_q <= CTRL_W'(wb_merge(WB_W'(ctrl_q), wbs.wbs_dat_i, wbs.wbs_sel_i));
         if (wr_pre_c)  pre_q  <= PRE_W'(wb_merge(WB_W'(pre_q), wbs.wbs_dat_i, wbs.wbs_sel_i));
      end
   end

   // Prescaler: held at reload while disabled, restarted by tick or COUNT write
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n)                                     pre_cnt_q <= '0;
      else if (!ctrl_q[CTRL_EN] || wr_count_c || tick_c) pre_cnt_q <= pre_q;
      else                                               pre_cnt_q <= pre_cnt_q - PRE_W'(1);
   end

   // Next digit value on a tick and whether it wraps
   always_comb begin
      limit_c    = ctrl_q[CTRL_HEX] ? 4'hF : 4'h9;
      count_nx_c = count_q;
      wrap_hit_c = 1'b0;
      if (ctrl_q[CTRL_DOWN]) begin
         if (count_q == '0) begin
            count_nx_c = limit_c;
            wrap_hit_c = 1'b1;
         end else begin
            count_nx_c = count_q - DIG_W'(1);
         end
      end else if (count_q >= limit_c) begin
         count_nx_c = '0;
         wrap_hit_c = 1'b1;
      end else begin
         count_nx_c = count_q + DIG_W'(1);
      end
   end

   // Digit counter and sticky wrap flag (set beats clear)
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         if (wr_count_c)  count_q <= DIG_W'(wb_merge(WB_W'(count_q), wbs.wbs_dat_i, wbs.wbs_sel_i));
         else if (tick_c) count_q <= count_nx_c;
         wrap_q <= (tick_c && wrap_hit_c) || (wrap_q && !clr_c);
      end
   end

   // Interrupt level
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) irq_o <= 1'b0;
      else           irq_o <= wrap_q && ctrl_q[CTRL_IRQ_EN];
   end

   // Polarity pin synchroniser
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) pol_q <= '0;
      else           pol_q <= {pol_q[0], digit_pol_in};
   end

   seg7_digit_ctrl_decode u_decode (
      .digit (count_q),
      .seg_c (seg_c)
   );

   // Registered pad drive
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         digit0_out <= SEG_TABLE[0];
         digit0_oeb <= '1;
      end else begin
         digit0_out <= (ctrl_q[CTRL_BLANK] ? '0 : seg_c) ^ {PAD_W{pol_q[1]}};
         digit0_oeb <= ctrl_q[CTRL_OE] ? '0 : '1;
      end
   end

endmodule

// File: tb/tb_seg7_digit_ctrl.sv
// Self-checking bench for seg7_digit_ctrl.
module tb_seg7_digit_ctrl;

   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam logic [7:0]  A_CTRL = 8'h00, A_PRE = 8'h04, A_COUNT = 8'h08, A_STAT = 8'h0C;
   localparam logic [6:0]  SEG_REF [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef struct {
      logic [3:0]  cnt;
      logic [31:0] ctrl;
      logic [6:0]  exp_out;
      logic [6:0]  exp_oeb;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pol = 1'b0;
   logic [6:0] out, oeb;
   logic       irq;
   int         checks = 0;
   int         failures = 0;

   seg7_digit_ctrl_if bus();

   seg7_digit_ctrl dut (
      .wb_clk_i     (clk),
      .wb_rst_n     (rst_n),
      .wbs          (bus),
      .digit_pol_in (pol),
      .digit0_out   (out),
      .digit0_oeb   (oeb),
      .irq_o        (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic wb_cycle(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdat);
      bit got;
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
      bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
      got = 1'b0; rdat = '0;
      for (int i = 0; i < 4 && !got; i++) begin
         @(negedge clk);
         if (bus.wbs_ack_o) begin got = 1'b1; rdat = bus.wbs_dat_o; end
      end
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
      if (!got) begin
         checks++; failures++;
         $display("FAIL bus_timeout adr=%h", adr);
      end
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] dat);
      logic [31:0] r;
      wb_cycle(BASE + 32'(off), 1'b1, dat, 4'hF, r);
   endtask

   task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string name);
      logic [31:0] r;
      wb_cycle(BASE + 32'(off), 1'b0, 32'h0, 4'hF, r);
      check(name, r, exp);
   endtask

   initial begin
      vec_t        vecs [19];
      logic [31:0] r, dat_or;
      logic [5:0]  pat;
      int          acks;

      for (int i = 0; i < 16; i++) vecs[i] = '{4'(i), 32'h00, SEG_REF[i], 7'h7F};
      vecs[16] = '{4'h3, 32'h08, 7'h00,       7'h7F};
      vecs[17] = '{4'h9, 32'h10, SEG_REF[9],  7'h00};
      vecs[18] = '{4'hA, 32'h18, 7'h00,       7'h00};

      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
      bus.wbs_sel_i = '0;   bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // reset state
      check("rst_ack", bus.wbs_ack_o, 0);
      check("rst_dat", bus.wbs_dat_o, 0);
      check("rst_out", out, 7'h3F);
      check("rst_oeb", oeb, 7'h7F);
      check("rst_irq", irq, 0);
      rd(A_CTRL, 0, "rst_ctrl");
      rd(A_PRE, 0, "rst_pre");
      rd(A_COUNT, 0, "rst_count");
      rd(A_STAT, 0, "rst_stat");

      // decode / blank / oe table
      foreach (vecs[i]) begin
         wr(A_CTRL, vecs[i].ctrl);
         wr(A_COUNT, 32'(vecs[i].cnt));
         @(negedge clk);
         check($sformatf("tbl_out[%0d]", i), out, vecs[i].exp_out);
         check($sformatf("tbl_oeb[%0d]", i), oeb, vecs[i].exp_oeb);
      end

      // decimal up count every 4 cycles with wrap
      wr(A_CTRL, 0); wr(A_COUNT, 0); wr(A_STAT, 1); wr(A_PRE, 3); wr(A_CTRL, 32'h11);
      @(negedge clk);
      check("t2_oeb", oeb, 7'h00);
      for (int j = 1; j <= 10; j++) begin
         repeat (4) @(negedge clk);
         check($sformatf("t2_seq[%0d]", j), out, SEG_REF[j % 10]);
      end
      wr(A_CTRL, 0);
      rd(A_STAT, 1, "t2_wrap");

      // hex down wrap, interrupt and clear
      wr(A_STAT, 1); wr(A_PRE, 0); wr(A_COUNT, 0); wr(A_CTRL, 32'h27);
      @(negedge clk);
      check("t3_irq_lag", irq, 0);
      @(negedge clk);
      check("t3_out", out, 7'h71);
      check("t3_irq", irq, 1);
      wr(A_CTRL, 32'h22);
      rd(A_STAT, 1, "t3_wrap");
      wr(A_STAT, 1);
      @(negedge clk);
      check("t3_irq_clr", irq, 0);
      rd(A_STAT, 0, "t3_stat_clr");
      // wrap set on the same edge as W1C
      wr(A_CTRL, 32'h26); wr(A_STAT, 1); wr(A_COUNT, 1); wr(A_CTRL, 32'h27);
      wr(A_STAT, 1); wr(A_CTRL, 32'h26);
      rd(A_STAT, 1, "t3_set_wins");
      check("t3_set_irq", irq, 1);

      // pad polarity via synchroniser, then blank
      wr(A_CTRL, 0); wr(A_STAT, 1); wr(A_COUNT, 8);
      @(negedge clk);
      check("t4_pre", out, 7'h7F);
      pol = 1'b1;
      repeat (2) @(negedge clk);
      check("t4_sync_lag", out, 7'h7F);
      @(negedge clk);
      check("t4_pol", out, 7'h00);
      wr(A_CTRL, 32'h08);
      @(negedge clk);
      check("t4_blank_pol", out, 7'h7F);
      pol = 1'b0;
      repeat (3) @(negedge clk);
      check("t4_blank", out, 7'h00);

      // COUNT write coincident with a tick
      wr(A_CTRL, 0); wr(A_PRE, 3); wr(A_COUNT, 0); wr(A_CTRL, 1);
      repeat (2) @(negedge clk);
      wr(A_COUNT, 5);
      @(negedge clk);
      check("t5_written", out, SEG_REF[5]);
      repeat (3) @(negedge clk);
      check("t5_hold", out, SEG_REF[5]);
      @(negedge clk);
      check("t5_next", out, SEG_REF[6]);
      // COUNT write between ticks restarts the prescaler
      wr(A_CTRL, 0); wr(A_COUNT, 0); wr(A_CTRL, 1); wr(A_COUNT, 2);
      repeat (4) @(negedge clk);
      check("t5_reload_hold", out, SEG_REF[2]);
      @(negedge clk);
      check("t5_reload_next", out, SEG_REF[3]);
      wr(A_CTRL, 0);

      // software-loaded value above 9 in decimal mode
      wr(A_STAT, 1); wr(A_PRE, 0); wr(A_COUNT, 12); wr(A_CTRL, 1); wr(A_CTRL, 0);
      rd(A_COUNT, 1, "dec_over_up");
      rd(A_STAT, 1, "dec_over_up_wrap");
      wr(A_STAT, 1); wr(A_COUNT, 12); wr(A_CTRL, 5); wr(A_CTRL, 4);
      rd(A_COUNT, 10, "dec_over_down");
      rd(A_STAT, 0, "dec_over_down_wrap");
      wr(A_CTRL, 0);

      // bus corners: out of window, unmapped offset, byte lanes
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
      bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = BASE + 32'h100;
      acks = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.wbs_ack_o) acks++;
      end
      check("t6_oow_ack", acks, 0);
      bus.wbs_adr_i = BASE + 32'h40;
      pat = '0; dat_or = '0;
      repeat (6) begin
         @(negedge clk);
         pat = {pat[4:0], bus.wbs_ack_o};
         dat_or = dat_or | bus.wbs_dat_o;
      end
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
      check("t6_ack_pattern", 32'(pat), 32'h2A);
      check("t6_unmapped_dat", dat_or, 0);
      wr(8'h40, 32'hFFFF_FFFF);
      rd(8'h40, 0, "t6_unmapped_rd");
      wr(A_PRE, 32'hFFFF_FFFF);
      rd(A_PRE, 32'h00FF_FFFF, "t6_pre_width");
      wr(A_PRE, 0);
      wb_cycle(BASE + 32'(A_PRE), 1'b1, 32'hFFFF_FFFF, 4'b0001, r);
      rd(A_PRE, 32'h0000_00FF, "t6_pre_sel");

      // randomized runs against an arithmetic model of tick count
      for (int it = 0; it < 24; it++) begin
         int hex, down, ien, pre, d, m, s, t, fin, wrap;
         hex  = int'($urandom_range(0, 1));
         down = int'($urandom_range(0, 1));
         ien  = int'($urandom_range(0, 1));
         pre  = int'($urandom_range(0, 5));
         d    = int'($urandom_range(1, 40));
         m    = hex ? 16 : 10;
         s    = int'($urandom_range(0, m - 1));
         wr(A_CTRL, 0); wr(A_STAT, 1); wr(A_PRE, 32'(pre)); wr(A_COUNT, 32'(s));
         wr(A_CTRL, 32'(16 | 1 | (hex << 1) | (down << 2) | (ien << 5)));
         repeat (d) @(negedge clk);
         wr(A_CTRL, 32'(16 | (hex << 1) | (down << 2) | (ien << 5)));
         t = (d + 2) / (pre + 1);
         if (down) begin
            fin = (s - t) % m;
            if (fin < 0) fin += m;
            wrap = (t > s) ? 1 : 0;
         end else begin
            fin  = (s + t) % m;
            wrap = (s + t >= m) ? 1 : 0;
         end
         rd(A_COUNT, 32'(fin), $sformatf("rnd_count[%0d]", it));
         rd(A_STAT, 32'(wrap), $sformatf("rnd_wrap[%0d]", it));
         check($sformatf("rnd_irq[%0d]", it), irq, 32'(wrap & ien));
         check($sformatf("rnd_out[%0d]", it), out, SEG_REF[fin]);
      end

      // reset during an ack drops it
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
      bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = BASE + 32'(A_COUNT); bus.wbs_dat_i = 32'h7;
      @(posedge clk);
      #1;
      check("rst_mid_ack_up", bus.wbs_ack_o, 1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_ack_drop", bus.wbs_ack_o, 0);
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rd(A_COUNT, 0, "rst_mid_count");
      check("rst_mid_out", out, 7'h3F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
